// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared frame definitions for the serial shift link
//               (receiver FSM states and start/stop bit levels).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd2,
        RESYNC = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/rx_shreg.sv
`default_nettype none
// ============================================================================
// Module      : rx_shreg
// Description : WIDTH-bit receive shift register with enable and selectable
//               bit order (first bit ends in the MSB or in the LSB).
// Revision    : 1.0 - initial release
// ============================================================================
module rx_shreg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             din_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sh_d = {sh_q[WIDTH-2:0], din_i};
        end else begin : g_lsb_first
            assign sh_d = {din_i, sh_q[WIDTH-1:1]};
        end
    endgenerate

    // Shift one bit in on each enabled cycle, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (en_i) begin
            sh_q <= sh_d;
        end
    end

    assign q_o = sh_q;

endmodule : rx_shreg
`default_nettype wire

// File: rtl/shift_rx.sv
`default_nettype none
// ============================================================================
// Module      : shift_rx
// Description : Serial-to-parallel frame receiver. Detects a start bit,
//               shifts in WIDTH data bits, checks the stop bit and holds
//               each good word in a one-entry valid/ready buffer, with
//               framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rx
    import shift_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] sh;
    logic             shift_en;

    // The shift register only moves while data bits are being sampled, so
    // it still holds the complete word when the stop bit arrives.
    assign shift_en = sin_en && (state_q == DATA);

    rx_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (shift_en),
        .din_i (sin),
        .q_o   (sh)
    );

    // Next-state, counter, output buffer and flag logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q && !dout_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sin_en && (sin == START_BIT)) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (sin_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (sin_en) begin
                    if (sin == STOP_BIT) begin
                        state_d = IDLE;
                        // A word accepted on this same edge frees the buffer.
                        if (!valid_q || dout_ready) begin
                            dout_d  = sh;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        state_d = RESYNC;
                        ferr_d  = 1'b1;
                    end
                end
            end
            RESYNC: begin
                // Wait for the line to return high so a stuck-low line
                // cannot be mistaken for a start bit.
                if (sin_en && (sin == STOP_BIT)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule : shift_rx
`default_nettype wire

// File: tb/tb_shift_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rx
// Description : Self-checking bench for shift_rx, one instance per bit order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rx;

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic       sin_en;
    logic       dout_ready;
    logic [3:0] dout_m, dout_l;
    logic       valid_m, valid_l;
    logic       ferr_m, ferr_l;
    logic       ovr_m, ovr_l;

    int checks = 0;
    int errors = 0;

    shift_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_en     (sin_en),
        .dout       (dout_m),
        .dout_valid (valid_m),
        .dout_ready (dout_ready),
        .frame_err  (ferr_m),
        .overrun    (ovr_m)
    );

    shift_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_en     (sin_en),
        .dout       (dout_l),
        .dout_valid (valid_l),
        .dout_ready (dout_ready),
        .frame_err  (ferr_l),
        .overrun    (ovr_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;      // data[3] is sent first
        int         gap;       // one strobe every 'gap' cycles
        logic [3:0] exp_msb;
        logic [3:0] exp_lsb;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One strobed bit; gap-1 unstrobed cycles with a toggling line first.
    task automatic send_bit(input logic b, input int gap, input logic rdy);
        for (int k = 0; k < gap - 1; k++) begin
            sin_en = 1'b0;
            sin    = ~sin;
            @(posedge clk); #1;
        end
        sin        = b;
        sin_en     = 1'b1;
        dout_ready = rdy;
        @(posedge clk); #1;
        sin_en     = 1'b0;
        dout_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic stop, input int gap,
                              input logic rdy_on_stop);
        send_bit(1'b0, gap, 1'b0);
        for (int i = 3; i >= 0; i--) send_bit(d[i], gap, 1'b0);
        send_bit(stop, gap, rdy_on_stop);
    endtask

    task automatic accept();
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        check("accept_valid_m", {31'd0, valid_m}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{data: 4'b1011, gap: 1, exp_msb: 4'b1011, exp_lsb: 4'b1101};
        vecs[1] = '{data: 4'b1011, gap: 3, exp_msb: 4'b1011, exp_lsb: 4'b1101};
        vecs[2] = '{data: 4'b0110, gap: 1, exp_msb: 4'b0110, exp_lsb: 4'b0110};
        vecs[3] = '{data: 4'b0011, gap: 2, exp_msb: 4'b0011, exp_lsb: 4'b1100};
        vecs[4] = '{data: 4'b1000, gap: 1, exp_msb: 4'b1000, exp_lsb: 4'b0001};

        // Reset with a low, strobed line.
        rst_n = 1'b0; sin = 1'b0; sin_en = 1'b1; dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_m",  {28'd0, dout_m}, 32'd0);
        check("rst_valid_m", {31'd0, valid_m}, 32'd0);
        check("rst_ferr_m",  {31'd0, ferr_m}, 32'd0);
        check("rst_ovr_m",   {31'd0, ovr_m}, 32'd0);
        check("rst_valid_l", {31'd0, valid_l}, 32'd0);

        rst_n = 1'b1; sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sin_en = 1'b0;
        check("idle_valid_m", {31'd0, valid_m}, 32'd0);
        check("idle_ferr_m",  {31'd0, ferr_m}, 32'd0);

        // Table-driven good frames, both bit orders.
        foreach (vecs[v]) begin
            send_frame(vecs[v].data, 1'b1, vecs[v].gap, 1'b0);
            check($sformatf("v%0d_dout_m", v),  {28'd0, dout_m}, {28'd0, vecs[v].exp_msb});
            check($sformatf("v%0d_dout_l", v),  {28'd0, dout_l}, {28'd0, vecs[v].exp_lsb});
            check($sformatf("v%0d_valid_m", v), {31'd0, valid_m}, 32'd1);
            check($sformatf("v%0d_valid_l", v), {31'd0, valid_l}, 32'd1);
            check($sformatf("v%0d_flags", v),   {30'd0, ferr_m, ovr_m}, 32'd0);
            accept();
        end

        // Framing error, then a held-low line, then recovery.
        send_frame(4'b1011, 1'b0, 1, 1'b0);
        check("ferr_pulse", {31'd0, ferr_m}, 32'd1);
        check("ferr_valid", {31'd0, valid_m}, 32'd0);
        check("ferr_ovr",   {31'd0, ovr_m}, 32'd0);
        @(posedge clk); #1;
        check("ferr_one_cycle", {31'd0, ferr_m}, 32'd0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1, 1'b0);
        check("low_line_valid", {31'd0, valid_m}, 32'd0);
        check("low_line_ferr",  {31'd0, ferr_m}, 32'd0);
        send_bit(1'b1, 1, 1'b0);
        send_frame(4'b0110, 1'b1, 1, 1'b0);
        check("resync_dout", {28'd0, dout_m}, 32'h6);
        check("resync_valid", {31'd0, valid_m}, 32'd1);
        accept();

        // Overrun: second frame arrives while buffer full and not accepted.
        send_frame(4'b1011, 1'b1, 1, 1'b0);
        send_frame(4'b0011, 1'b1, 1, 1'b0);
        check("ovr_pulse", {31'd0, ovr_m}, 32'd1);
        check("ovr_ferr",  {31'd0, ferr_m}, 32'd0);
        check("ovr_dout",  {28'd0, dout_m}, 32'hB);
        check("ovr_valid", {31'd0, valid_m}, 32'd1);
        @(posedge clk); #1;
        check("ovr_one_cycle", {31'd0, ovr_m}, 32'd0);
        check("ovr_dout_held", {28'd0, dout_m}, 32'hB);
        accept();

        // Accept and load on the same edge.
        send_frame(4'b1011, 1'b1, 1, 1'b0);
        send_frame(4'b0011, 1'b1, 1, 1'b1);
        check("sim_dout_m",  {28'd0, dout_m}, 32'h3);
        check("sim_dout_l",  {28'd0, dout_l}, 32'hC);
        check("sim_valid",   {31'd0, valid_m}, 32'd1);
        check("sim_no_ovr",  {31'd0, ovr_m}, 32'd0);
        accept();

        // Reset mid-DATA with a word in the buffer.
        send_frame(4'b1011, 1'b1, 1, 1'b0);
        send_bit(1'b0, 1, 1'b0);
        send_bit(1'b1, 1, 1'b0);
        send_bit(1'b1, 1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_valid", {31'd0, valid_m}, 32'd0);
        check("mid_rst_dout",  {28'd0, dout_m}, 32'd0);
        check("mid_rst_flags", {30'd0, ferr_m, ovr_m}, 32'd0);
        sin = 1'b1;
        @(posedge clk); #1;
        send_frame(4'b0110, 1'b1, 1, 1'b0);
        check("post_rst_dout",  {28'd0, dout_m}, 32'h6);
        check("post_rst_valid", {31'd0, valid_m}, 32'd1);
        check("post_rst_flags", {30'd0, ferr_m, ovr_m}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_rx
`default_nettype wire
